// File: rtl/csr_hpm_counters_if.sv
// csr_hpm_counters_if: CSR access bus between the CSR unit and the performance counter block.
interface csr_hpm_counters_if #(parameter int XLEN = 64);
  logic            CSRWriteM;
  logic            CSRMWriteM;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic [XLEN-1:0] CSRReadValM;
  logic            IllegalAccessM;
  modport master (output CSRWriteM, CSRMWriteM, CSRAdrM, CSRWriteValM, input CSRReadValM, IllegalAccessM);
  modport slave  (input CSRWriteM, CSRMWriteM, CSRAdrM, CSRWriteValM, output CSRReadValM, IllegalAccessM);
endinterface

// File: rtl/csr_hpm_counters.sv
// csr_hpm_counters: cycle/instret/hpm counters with event selectors, mode filtering and overflow interrupt.
module csr_hpm_counters #(
  parameter int XLEN      = 64,
  parameter int NCOUNTERS = 32,
  parameter int NEVENTS   = 32,
  parameter int CNTW      = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               InstrRetiredM,
  input  logic [NEVENTS-1:0] EventM,
  input  logic [1:0]         PrivilegeModeW,
  input  logic [31:0]        MCOUNTINHIBIT_REGW,
  input  logic [31:0]        MCOUNTEREN_REGW,
  input  logic [31:0]        SCOUNTEREN_REGW,
  csr_hpm_counters_if.slave  bus,
  output logic               LcofIrqM
);
  logic [CNTW-1:0] cnt_q [32];
  logic [CNTW-1:0] cnt_d [32];
  logic [7:0]      sel_q [32];
  logic [7:0]      sel_d [32];
  logic [31:0]     of_q, of_d, minh_q, minh_d, sinh_q, sinh_d, uinh_q, uinh_d;
  logic            lcof_q, lcof_d;
  logic [4:0]      idx;
  logic [6:0]      page;
  logic            is_mlo, is_mhi, is_ulo, is_uhi, is_cnt, is_evt, is_hi;
  logic            cnt_exists, evt_exists, priv_m, illegal;
  logic            wr_lo, wr_hi, wr_evt;
  logic [63:0]     wd, cv, rd, lo_mask;
  logic [XLEN-1:0] evt_rd;
  logic [255:0]    ev_ext;
  logic [31:0]     inc, hit, ovf, ew;
  assign idx        = bus.CSRAdrM[4:0];
  assign page       = bus.CSRAdrM[11:5];
  assign is_mlo     = page == 7'h58;
  assign is_mhi     = page == 7'h5C && XLEN == 32;
  assign is_ulo     = page == 7'h60;
  assign is_uhi     = page == 7'h64 && XLEN == 32;
  assign is_evt     = page == 7'h19;
  assign is_cnt     = is_mlo | is_mhi | is_ulo | is_uhi;
  assign is_hi      = is_mhi | is_uhi;
  assign priv_m     = PrivilegeModeW == 2'd3;
  assign evt_exists = idx >= 5'd3 && 32'(idx) < NCOUNTERS;
  assign cnt_exists = idx == 5'd0 || idx == 5'd2 || evt_exists;
  // Anything outside the counter and event windows is not ours, so it is flagged.
  assign illegal = is_cnt ? (!cnt_exists || ((is_ulo | is_uhi) && bus.CSRWriteM) ||
                             (!priv_m && !MCOUNTEREN_REGW[idx]) ||
                             (PrivilegeModeW == 2'd0 && !SCOUNTEREN_REGW[idx]))
                 : is_evt ? (!evt_exists || !priv_m) : 1'b1;
  assign wr_lo   = bus.CSRMWriteM && !illegal && is_mlo;
  assign wr_hi   = bus.CSRMWriteM && !illegal && is_mhi;
  assign wr_evt  = bus.CSRMWriteM && !illegal && is_evt;
  assign wd      = 64'(bus.CSRWriteValM);
  assign lo_mask = XLEN == 64 ? '1 : 64'hFFFF_FFFF;
  assign ev_ext  = 256'(EventM);
  assign cv      = 64'(cnt_q[idx]);
  always_comb begin
    evt_rd         = '0;
    evt_rd[7:0]    = sel_q[idx];
    evt_rd[XLEN-1] = of_q[idx];
    evt_rd[XLEN-2] = minh_q[idx];
    evt_rd[XLEN-3] = sinh_q[idx];
    evt_rd[XLEN-4] = uinh_q[idx];
  end
  assign rd                 = is_evt ? 64'(evt_rd) : is_hi ? {32'b0, cv[63:32]} : cv;
  assign bus.CSRReadValM    = illegal ? '0 : XLEN'(rd);
  assign bus.IllegalAccessM = illegal;
  assign LcofIrqM           = lcof_q;
  always_comb begin
    inc    = '0;
    hit    = '0;
    ovf    = '0;
    ew     = '0;
    lcof_d = 1'b0;
    for (int i = 0; i < 32; i++) begin
      hit[i] = idx == 5'(i);
      inc[i] = (i == 0 ? 1'b1 : i == 2 ? InstrRetiredM :
                (i >= 3 && i < NCOUNTERS) ? (sel_q[i] != 8'd0 && 32'(sel_q[i]) <= NEVENTS && ev_ext[sel_q[i] - 8'd1]) : 1'b0)
               && !MCOUNTINHIBIT_REGW[i]
               && !(i >= 3 && (PrivilegeModeW == 2'd3 ? minh_q[i] : PrivilegeModeW == 2'd1 ? sinh_q[i] :
                               PrivilegeModeW == 2'd0 ? uinh_q[i] : 1'b0));
      ew[i]  = wr_evt && hit[i];
      // A counter write swallows the increment, so it can never wrap in that cycle.
      ovf[i] = i >= 3 && inc[i] && (&cnt_q[i]) && !((wr_lo || wr_hi) && hit[i]);
      cnt_d[i] = (wr_lo && hit[i]) ? (cnt_q[i] & ~CNTW'(lo_mask)) | (wd[CNTW-1:0] & CNTW'(lo_mask))
               : (wr_hi && hit[i]) ? (cnt_q[i] & CNTW'(64'hFFFF_FFFF)) | CNTW'(wd << 32)
               : cnt_q[i] + CNTW'(inc[i]);
      sel_d[i]  = ew[i] ? wd[7:0] : sel_q[i];
      of_d[i]   = ew[i] ? wd[XLEN-1] : of_q[i] | ovf[i];
      minh_d[i] = ew[i] ? wd[XLEN-2] : minh_q[i];
      sinh_d[i] = ew[i] ? wd[XLEN-3] : sinh_q[i];
      uinh_d[i] = ew[i] ? wd[XLEN-4] : uinh_q[i];
      lcof_d    = lcof_d | (ovf[i] && !of_q[i] && !ew[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      of_q   <= '0;
      minh_q <= '0;
      sinh_q <= '0;
      uinh_q <= '0;
      lcof_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      of_q   <= of_d;
      minh_q <= minh_d;
      sinh_q <= sinh_d;
      uinh_q <= uinh_d;
      lcof_q <= lcof_d;
    end
  end
endmodule

// File: tb/tb_csr_hpm_counters.sv
// tb_csr_hpm_counters: directed checks of the hpm counter block (RV64 instance plus an RV32 instance).
module tb_csr_hpm_counters;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_ret = 1'b0;
  logic [31:0] event_m = '0;
  logic [1:0]  priv = 2'd3;
  logic [31:0] inhibit = '0, mcen = '0, scen = '0;
  logic        lcof64, lcof32;
  logic [63:0] cyc = '0;
  int          n_chk = 0, n_fail = 0;
  csr_hpm_counters_if #(.XLEN(64)) b64 ();
  csr_hpm_counters_if #(.XLEN(32)) b32 ();
  csr_hpm_counters #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .InstrRetiredM(instr_ret), .EventM(event_m), .PrivilegeModeW(priv),
    .MCOUNTINHIBIT_REGW(inhibit), .MCOUNTEREN_REGW(mcen), .SCOUNTEREN_REGW(scen),
    .bus(b64.slave), .LcofIrqM(lcof64));
  csr_hpm_counters #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .InstrRetiredM(instr_ret), .EventM(event_m), .PrivilegeModeW(priv),
    .MCOUNTINHIBIT_REGW(inhibit), .MCOUNTEREN_REGW(mcen), .SCOUNTEREN_REGW(scen),
    .bus(b32.slave), .LcofIrqM(lcof32));
  always #5 clk = ~clk;
  // Reference for counter 0: cycles since reset released.
  always @(posedge clk) cyc <= reset ? 64'd0 : cyc + 64'd1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr64(input logic [11:0] a, input logic [63:0] v);
    b64.CSRWriteM = 1'b1; b64.CSRMWriteM = 1'b1; b64.CSRAdrM = a; b64.CSRWriteValM = v;
    tick();
    b64.CSRWriteM = 1'b0; b64.CSRMWriteM = 1'b0;
  endtask
  task automatic wr32(input logic [11:0] a, input logic [31:0] v);
    b32.CSRWriteM = 1'b1; b32.CSRMWriteM = 1'b1; b32.CSRAdrM = a; b32.CSRWriteValM = v;
    tick();
    b32.CSRWriteM = 1'b0; b32.CSRMWriteM = 1'b0;
  endtask
  task automatic rd64(input string tag, input logic [11:0] a, input logic [63:0] exp, input logic exp_ill);
    b64.CSRAdrM = a;
    #1;
    check({tag, "_val"}, b64.CSRReadValM, exp);
    check({tag, "_ill"}, 64'(b64.IllegalAccessM), 64'(exp_ill));
  endtask
  task automatic pulse();
    event_m = 32'h10;
    tick();
    event_m = '0;
  endtask
  initial begin
    b64.CSRWriteM = 0; b64.CSRMWriteM = 0; b64.CSRAdrM = '0; b64.CSRWriteValM = '0;
    b32.CSRWriteM = 0; b32.CSRMWriteM = 0; b32.CSRAdrM = '0; b32.CSRWriteValM = '0;
    tick();
    reset = 1'b0;
    rd64("rst_cnt0", 12'hB00, 64'd0, 1'b0);
    rd64("rst_evt3", 12'h323, 64'd0, 1'b0);
    check("rst_lcof", 64'(lcof64), 64'd0);
    repeat (10) tick();
    rd64("free_b00", 12'hB00, 64'd10, 1'b0);
    priv = 2'd0; mcen = 32'h1; scen = 32'h1;
    rd64("free_c00_u", 12'hC00, 64'd10, 1'b0);
    priv = 2'd3;
    wr64(12'h323, 64'd5);
    wr64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
    pulse();
    check("ovf_pre_lcof", 64'(lcof64), 64'd0);
    pulse();
    check("ovf_lcof_hi", 64'(lcof64), 64'd1);
    rd64("ovf_cnt", 12'hB03, 64'd0, 1'b0);
    rd64("ovf_of", 12'h323, 64'h8000_0000_0000_0005, 1'b0);
    tick();
    check("ovf_lcof_lo", 64'(lcof64), 64'd0);
    pulse();
    rd64("ovf_cnt3", 12'hB03, 64'd1, 1'b0);
    check("ovf_nopulse", 64'(lcof64), 64'd0);
    tick();
    check("ovf_nopulse2", 64'(lcof64), 64'd0);
    instr_ret = 1'b1;
    wr64(12'hB02, 64'd100);
    instr_ret = 1'b0;
    rd64("coll_b02", 12'hB02, 64'd100, 1'b0);
    instr_ret = 1'b1;
    repeat (3) tick();
    instr_ret = 1'b0;
    rd64("inst_b02", 12'hB02, 64'd103, 1'b0);
    wr64(12'h323, 64'h1000_0000_0000_0005);
    wr64(12'hB03, 64'd0);
    rd64("uinh_evt", 12'h323, 64'h1000_0000_0000_0005, 1'b0);
    priv = 2'd0;
    repeat (3) pulse();
    priv = 2'd3;
    repeat (2) pulse();
    rd64("uinh_cnt", 12'hB03, 64'd2, 1'b0);
    inhibit = 32'h8;
    pulse();
    inhibit = '0;
    rd64("mcinh_cnt", 12'hB03, 64'd2, 1'b0);
    wr64(12'h323, 64'd5);
    wr64(12'hB03, '1);
    b64.CSRWriteM = 1'b1; b64.CSRMWriteM = 1'b1; b64.CSRAdrM = 12'h323; b64.CSRWriteValM = 64'd5;
    event_m = 32'h10;
    tick();
    b64.CSRWriteM = 1'b0; b64.CSRMWriteM = 1'b0; event_m = '0;
    check("evcol_lcof", 64'(lcof64), 64'd0);
    rd64("evcol_cnt", 12'hB03, 64'd0, 1'b0);
    rd64("evcol_of", 12'h323, 64'd5, 1'b0);
    mcen = '1; scen = '0; priv = 2'd0;
    rd64("ill_c03_u", 12'hC03, 64'd0, 1'b1);
    priv = 2'd3;
    b64.CSRWriteM = 1'b1; b64.CSRMWriteM = 1'b1; b64.CSRAdrM = 12'hC00; b64.CSRWriteValM = 64'h55;
    #1;
    check("ill_wr_c00", 64'(b64.IllegalAccessM), 64'd1);
    tick();
    b64.CSRWriteM = 1'b0; b64.CSRMWriteM = 1'b0;
    rd64("ill_c00_kept", 12'hB00, cyc, 1'b0);
    rd64("ill_b01", 12'hB01, 64'd0, 1'b1);
    rd64("ill_c01", 12'hC01, 64'd0, 1'b1);
    rd64("ill_b83_64", 12'hB83, 64'd0, 1'b1);
    priv = 2'd1;
    rd64("ill_evt_s", 12'h323, 64'd0, 1'b1);
    priv = 2'd3;
    wr32(12'hB03, 32'h1234_5678);
    wr32(12'hB83, 32'h1);
    b32.CSRAdrM = 12'hB03;
    #1;
    check("x32_lo", 64'(b32.CSRReadValM), 64'h1234_5678);
    b32.CSRAdrM = 12'hB83;
    #1;
    check("x32_hi", 64'(b32.CSRReadValM), 64'd1);
    b32.CSRAdrM = 12'hC83;
    #1;
    check("x32_c83", 64'(b32.CSRReadValM), 64'd1);
    check("x32_ill", 64'(b32.IllegalAccessM), 64'd0);
    wr64(12'h323, 64'd5);
    wr64(12'hB03, '1);
    reset = 1'b1;
    event_m = 32'h10;
    tick();
    reset = 1'b0; event_m = '0;
    check("rstp_lcof", 64'(lcof64), 64'd0);
    rd64("rstp_cnt", 12'hB03, 64'd0, 1'b0);
    rd64("rstp_evt", 12'h323, 64'd0, 1'b0);
    tick();
    check("rstp_lcof2", 64'(lcof64), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
